mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: LATENCY, default 2, port cycles per access (legal range 1..15).
REQ-002 Parameter: AW, default 16, address width.
REQ-003 Parameter: DW, default 16, data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 if_req  in  1  fetch request from the IF stage; held high until if_ack.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_rdata  out  DW  fetched instruction, registered.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 mem_rd_req  in  1  load request from the MEM stage.
REQ-011 mem_wr_req  in  1  store request from the MEM stage.
REQ-012 mem_addr  in  AW  load/store address.
REQ-013 mem_wdata  in  DW  store data.
REQ-014 mem_rdata  out  DW  load data, registered.
REQ-015 mem_ack  out  1  one-cycle load/store completion pulse.
REQ-016 stall_if  out  1  hold the PC and IF/ID.
REQ-017 stall_mem  out  1  hold the pipeline at MEM and upstream.
REQ-018 port_en  out  1  shared memory access enable.
REQ-019 port_we  out  1  shared memory write enable.
REQ-020 port_addr  out  AW  shared memory address.
REQ-021 port_wdata  out  DW  shared memory write data.
REQ-022 port_rdata  in  DW  shared memory read data; valid in the last port_en cycle.
REQ-023 proto_err  out  1  sticky error flag.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, GNT_IF, GNT_MEM and ACK.
REQ-025 Arbitration in IDLE SHALL work as follows:
- any MEM request wins and the next state is GNT_MEM;
- else if_req gives GNT_IF;
- else the FSM stays in IDLE.
REQ-026 On entering a grant state, the FSM SHALL latch into internal registers:
- the winner's address;
- for MEM, wdata and we;
- a down-counter loaded with LATENCY-1.
REQ-027 In a grant state, port_en SHALL be 1 and port_addr, port_we and port_wdata SHALL be driven from the latched registers, stable for exactly LATENCY cycles.
REQ-028 When the counter is 0 in a grant state:
- port_rdata SHALL be captured into if_rdata or mem_rdata (the load case only);
- the next state SHALL be ACK, with the served source recorded.
REQ-029 In ACK, the served source's ack SHALL be 1 for exactly one cycle and port_en SHALL be 0.
REQ-030 From ACK, the FSM SHALL grant the other source only, and only if it is requesting; otherwise the next state is IDLE. The just-served source SHALL never be re-granted from ACK.
REQ-031 Latency: a request first seen in IDLE in cycle 0 SHALL get port_en in cycles 1..LATENCY and ack in cycle LATENCY+1.
REQ-032 stall_if SHALL equal if_req AND NOT if_ack, combinationally.
REQ-033 stall_mem SHALL equal (mem_rd_req OR mem_wr_req) AND NOT mem_ack, combinationally.
REQ-034 For a store, port_we SHALL be 1 for all LATENCY cycles and mem_rdata SHALL be left unchanged.
REQ-035 If mem_rd_req and mem_wr_req are both 1 when sampled for a grant:
- the access SHALL be treated as a store;
- proto_err SHALL set and stay set until reset.
REQ-036 If a request drops before its ack, the latched access SHALL complete, the ack SHALL still pulse, and proto_err SHALL NOT set.
REQ-037 Changes to the address or data inputs during a grant SHALL have no effect on the port outputs.
REQ-038 With LATENCY=1, the counter SHALL load 0 and the grant state SHALL last one cycle.
REQ-039 if_rdata and mem_rdata SHALL hold their value until the next capture of the same source.

Reset
REQ-040 While rst=0, the following SHALL be forced immediately, without waiting for a clock edge:
- state IDLE;
- counter 0;
- port_en, port_we, if_ack, mem_ack and proto_err at 0;
- port_addr, port_wdata, if_rdata and mem_rdata at 0.
REQ-041 Reset asserted mid-grant SHALL abort the access with no ack issued. After release, arbitration SHALL restart from IDLE on the first rising edge.

Verification
REQ-042 LATENCY=2; if_req=1 with addr 0x0010 in cycle 0 and port_rdata=0xA5A5 -> port_en in cycles 1-2, if_ack in cycle 3, if_rdata=0xA5A5.
REQ-043 if_req and mem_rd_req asserted together in cycle 0 -> MEM ack in cycle 3, IF granted in cycle 4, IF ack in cycle 6, stall_if=1 in cycles 0-5.
REQ-044 mem_wr_req held with addr 0x0040 and wdata 0x1234 -> port_we=1 and port_wdata=0x1234 for 2 cycles, mem_ack once, mem_rdata unchanged.
REQ-045 Both sources requesting continuously -> grants alternate MEM, IF, MEM, IF; no source is acked twice in a row while the other waits.
REQ-046 mem_rd_req and mem_wr_req both 1 -> store performed, proto_err=1 until rst=0.
REQ-047 rst=0 during cycle 1 of GNT_IF -> port_en=0 immediately, no if_ack; new if_req after release is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetches and MEM loads/stores; MEM wins from IDLE and ACK hands over to the other source.
// Grant follows a request by one cycle, holds the port LATENCY cycles, then acks; requesters stall until acked.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          mem_rd_req,
  input  logic          mem_wr_req,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          port_en,
  output logic          port_we,
  output logic [AW-1:0] port_addr,
  output logic [DW-1:0] port_wdata,
  input  logic [DW-1:0] port_rdata,
  output logic          proto_err
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, ACK} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          we_q, we_d;
  logic          served_mem_q, served_mem_d;
  logic          proto_err_q, proto_err_d;
  logic          mem_req;
  logic          grant_if, grant_mem;

  assign mem_req = mem_rd_req | mem_wr_req;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    served_mem_d = served_mem_q;
    proto_err_d  = proto_err_q;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          grant_mem = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (cnt_q == 4'd0) begin
          state_d      = ACK;
          served_mem_d = (state_q == GNT_MEM);
          if (state_q == GNT_IF) begin
            if_rdata_d = port_rdata;
          end else if (!we_q) begin
            mem_rdata_d = port_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        // Only the source that was not just served may be granted here.
        state_d = IDLE;
        if (served_mem_q) begin
          grant_if = if_req;
        end else begin
          grant_mem = mem_req;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_mem) begin
      state_d = GNT_MEM;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      we_d    = mem_wr_req;
      cnt_d   = CNT_INIT;
      if (mem_rd_req && mem_wr_req) begin
        proto_err_d = 1'b1;
      end
    end else if (grant_if) begin
      state_d = GNT_IF;
      addr_d  = if_addr;
      we_d    = 1'b0;
      cnt_d   = CNT_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      served_mem_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      served_mem_q <= served_mem_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign port_en    = (state_q == GNT_IF) || (state_q == GNT_MEM);
  assign port_we    = (state_q == GNT_MEM) && we_q;
  assign port_addr  = addr_q;
  assign port_wdata = wdata_q;
  assign if_ack     = (state_q == ACK) && !served_mem_q;
  assign mem_ack    = (state_q == ACK) && served_mem_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign proto_err  = proto_err_q;
  assign stall_if   = if_req & ~if_ack;
  assign stall_mem  = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized two-requester run checked against a transaction-level memory model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int BOUND = 4 * (LAT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall_if;
  logic          stall_mem;
  logic          port_en;
  logic          port_we;
  logic [AW-1:0] port_addr;
  logic [DW-1:0] port_wdata;
  logic [DW-1:0] port_rdata;
  logic          proto_err;

  logic [DW-1:0] dev_mem [256];
  logic [DW-1:0] exp_mem_rdata;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign port_rdata = dev_mem[port_addr[7:0]];

  mem_port_arbiter #(.LATENCY(LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .port_en(port_en), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_rdata(port_rdata), .proto_err(proto_err)
  );

  task automatic drive_idle();
    if_req     = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({port_en, port_we, if_ack, mem_ack, proto_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en/we/iack/mack/err=%b, want 00000",
               {port_en, port_we, if_ack, mem_ack, proto_err});
    end
    n_checks++;
    if (port_addr !== '0 || port_wdata !== '0 || if_rdata !== '0 || mem_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h mem_rdata=%h, want all 0",
               port_addr, port_wdata, if_rdata, mem_rdata);
    end
    if_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (port_en !== 1'b0 || if_ack !== 1'b0 || stall_if !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: port_en=%b if_ack=%b stall_if=%b, want 0 0 1", port_en, if_ack, stall_if);
    end
    if_req = 1'b0;
    rst = 1'b1;
    exp_mem_rdata = '0;
  endtask

  task automatic test_if_fetch();
    bit exp_en, exp_ack;
    dev_mem[8'h10] = 16'hA5A5;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 16'h0010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_en  = (c == 1 || c == 2);
      exp_ack = (c == 3);
      n_checks++;
      if (port_en !== exp_en || if_ack !== exp_ack || mem_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL if_fetch c%0d: port_en=%b if_ack=%b mem_ack=%b, want %b %b 0",
                 c, port_en, if_ack, mem_ack, exp_en, exp_ack);
      end
      if (exp_en) begin
        n_checks++;
        if (port_addr !== 16'h0010 || port_we !== 1'b0) begin
          n_fail++;
          $display("FAIL if_fetch_port c%0d: addr=%h we=%b, want 0010 0", c, port_addr, port_we);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (if_rdata !== 16'hA5A5) begin
          n_fail++;
          $display("FAIL if_fetch_data: if_rdata=%h, want a5a5", if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) if_req = 1'b0;
    end
  endtask

  task automatic test_if_mem_both();
    bit exp_en;
    logic [AW-1:0] exp_addr;
    dev_mem[8'h20] = 16'h5A5A;
    dev_mem[8'h30] = 16'h0F0F;
    @(posedge clk); #1;
    if_req = 1'b1;      if_addr  = 16'h0030;
    mem_rd_req = 1'b1;  mem_addr = 16'h0020;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_en = (c == 1 || c == 2 || c == 4 || c == 5);
      n_checks++;
      if (port_en !== exp_en || mem_ack !== (c == 3) || if_ack !== (c == 6) ||
          stall_if !== (c <= 5) || stall_mem !== (c <= 2)) begin
        n_fail++;
        $display("FAIL both c%0d: en=%b mack=%b iack=%b stall_if=%b stall_mem=%b, want %b %b %b %b %b",
                 c, port_en, mem_ack, if_ack, stall_if, stall_mem,
                 exp_en, c == 3, c == 6, c <= 5, c <= 2);
      end
      if (exp_en) begin
        exp_addr = (c < 3) ? 16'h0020 : 16'h0030;
        n_checks++;
        if (port_addr !== exp_addr || port_we !== 1'b0) begin
          n_fail++;
          $display("FAIL both_port c%0d: addr=%h we=%b, want %h 0", c, port_addr, port_we, exp_addr);
        end
      end
      if (c == 4 || c == 7) begin
        n_checks++;
        if (mem_rdata !== 16'h5A5A || (c == 7 && if_rdata !== 16'h0F0F)) begin
          n_fail++;
          $display("FAIL both_data c%0d: mem_rdata=%h if_rdata=%h, want 5a5a 0f0f", c, mem_rdata, if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) mem_rd_req = 1'b0;
      if (c == 6) if_req = 1'b0;
    end
    exp_mem_rdata = 16'h5A5A;
  endtask

  task automatic test_store();
    bit exp_en;
    int n_ack = 0;
    @(posedge clk); #1;
    mem_wr_req = 1'b1;
    mem_addr   = 16'h0040;
    mem_wdata  = 16'h1234;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_en = (c == 1 || c == 2);
      if (mem_ack === 1'b1) n_ack++;
      n_checks++;
      if (port_en !== exp_en || port_we !== exp_en || mem_ack !== (c == 3)) begin
        n_fail++;
        $display("FAIL store c%0d: en=%b we=%b mack=%b, want %b %b %b",
                 c, port_en, port_we, mem_ack, exp_en, exp_en, c == 3);
      end
      if (exp_en) begin
        n_checks++;
        if (port_addr !== 16'h0040 || port_wdata !== 16'h1234) begin
          n_fail++;
          $display("FAIL store_port c%0d: addr=%h wdata=%h, want 0040 1234", c, port_addr, port_wdata);
        end
      end
      if (c >= 4) begin
        n_checks++;
        if (mem_rdata !== exp_mem_rdata || proto_err !== 1'b0) begin
          n_fail++;
          $display("FAIL store_rdata c%0d: mem_rdata=%h err=%b, want %h 0", c, mem_rdata, proto_err, exp_mem_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 0) begin
        mem_addr  = 16'h0055;
        mem_wdata = 16'hFFFF;
      end
      if (c == 3) mem_wr_req = 1'b0;
    end
    n_checks++;
    if (n_ack != 1) begin
      n_fail++;
      $display("FAIL store_ack_count: got %0d acks, want 1", n_ack);
    end
  endtask

  task automatic test_drop();
    bit exp_en;
    dev_mem[8'h11] = 16'hBEEF;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 16'h0011;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_en = (c == 1 || c == 2);
      n_checks++;
      if (port_en !== exp_en || if_ack !== (c == 3) || stall_if !== (c == 0) || proto_err !== 1'b0) begin
        n_fail++;
        $display("FAIL drop c%0d: en=%b iack=%b stall_if=%b err=%b, want %b %b %b 0",
                 c, port_en, if_ack, stall_if, proto_err, exp_en, c == 3, c == 0);
      end
      if (c == 4) begin
        n_checks++;
        if (if_rdata !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL drop_data: if_rdata=%h, want beef", if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 0) begin
        if_req  = 1'b0;
        if_addr = 16'h00EE;
      end
    end
  endtask

  task automatic test_alternate();
    int n_acks = 0;
    int kind, want;
    localparam int N = 30;
    dev_mem[8'h21] = 16'h2121;
    dev_mem[8'h31] = 16'h3131;
    @(posedge clk); #1;
    if_req = 1'b1;      if_addr  = 16'h0031;
    mem_rd_req = 1'b1;  mem_addr = 16'h0021;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      if (if_ack === 1'b1 || mem_ack === 1'b1) begin
        kind = (if_ack === 1'b1 && mem_ack === 1'b1) ? 3 : (mem_ack === 1'b1 ? 2 : 1);
        want = (n_acks % 2 == 0) ? 2 : 1;
        n_checks++;
        if (kind != want) begin
          n_fail++;
          $display("FAIL alternate ack#%0d at c%0d: source=%0d, want %0d (2=MEM 1=IF)", n_acks, c, kind, want);
        end
        n_acks++;
      end
      @(posedge clk); #1;
    end
    drive_idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (n_acks != (N - 1) / (LAT + 1) || mem_rdata !== 16'h2121 || if_rdata !== 16'h3131) begin
      n_fail++;
      $display("FAIL alternate_total: acks=%0d mem_rdata=%h if_rdata=%h, want %0d 2121 3131",
               n_acks, mem_rdata, if_rdata, (N - 1) / (LAT + 1));
    end
    exp_mem_rdata = 16'h2121;
  endtask

  task automatic test_rdwr_err();
    bit exp_en;
    @(posedge clk); #1;
    mem_rd_req = 1'b1;
    mem_wr_req = 1'b1;
    mem_addr   = 16'h0042;
    mem_wdata  = 16'h7777;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_en = (c == 1 || c == 2);
      n_checks++;
      if (port_en !== exp_en || port_we !== exp_en || mem_ack !== (c == 3) || proto_err !== (c >= 1)) begin
        n_fail++;
        $display("FAIL rdwr c%0d: en=%b we=%b mack=%b err=%b, want %b %b %b %b",
                 c, port_en, port_we, mem_ack, proto_err, exp_en, exp_en, c == 3, c >= 1);
      end
      if (c >= 4) begin
        n_checks++;
        if (mem_rdata !== exp_mem_rdata) begin
          n_fail++;
          $display("FAIL rdwr_rdata c%0d: mem_rdata=%h, want %h", c, mem_rdata, exp_mem_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) drive_idle();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rdwr_sticky: proto_err=%b, want 1", proto_err);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (proto_err !== 1'b0 || mem_rdata !== '0) begin
      n_fail++;
      $display("FAIL rdwr_clear: proto_err=%b mem_rdata=%h, want 0 0000", proto_err, mem_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_mem_rdata = '0;
  endtask

  task automatic test_reset_mid();
    bit exp_en;
    dev_mem[8'h12] = 16'hC3C3;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 16'h0012;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (port_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: port_en=%b, want 1", port_en);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (port_en !== 1'b0 || if_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: port_en=%b if_ack=%b, want 0 0", port_en, if_ack);
    end
    if_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (port_en !== 1'b0 || if_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_hold c%0d: port_en=%b if_ack=%b, want 0 0", c, port_en, if_ack);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      exp_en = (c == 1 || c == 2);
      n_checks++;
      if (port_en !== exp_en || if_ack !== (c == 3)) begin
        n_fail++;
        $display("FAIL rst_mid_after c%0d: en=%b iack=%b, want %b %b", c, port_en, if_ack, exp_en, c == 3);
      end
      if (c == 4) begin
        n_checks++;
        if (if_rdata !== 16'hC3C3) begin
          n_fail++;
          $display("FAIL rst_mid_data: if_rdata=%h, want c3c3", if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) if_req = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [256];
    logic [AW-1:0] ia, ma, run_addr;
    logic [DW-1:0] mwd, ref_mrd, run_wd;
    bit if_pend, m_pend, m_wr, run_we, prev_en, iack_s, mack_s, ok;
    int run_len, wait_if, wait_m, expect_next, n_iack, n_mack;
    for (int i = 0; i < 256; i++) ref_mem[i] = dev_mem[i];
    ref_mrd = exp_mem_rdata;
    ia = '0; ma = '0; mwd = '0; run_addr = '0; run_wd = '0;
    if_pend = 0; m_pend = 0; m_wr = 0; run_we = 0; prev_en = 0;
    run_len = 0; wait_if = 0; wait_m = 0; expect_next = 0; n_iack = 0; n_mack = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      iack_s = (if_ack === 1'b1);
      mack_s = (mem_ack === 1'b1);
      n_checks++;
      if (stall_if !== (if_req & ~if_ack) || stall_mem !== ((mem_rd_req | mem_wr_req) & ~mem_ack) ||
          (iack_s && mack_s)) begin
        n_fail++;
        $display("FAIL rand_stall cyc%0d: stall_if=%b stall_mem=%b iack=%b mack=%b",
                 cyc, stall_if, stall_mem, if_ack, mem_ack);
      end
      if (port_en === 1'b1) begin
        if (!prev_en) begin
          run_len = 1; run_addr = port_addr; run_we = port_we; run_wd = port_wdata;
        end else begin
          run_len++;
          n_checks++;
          if (port_addr !== run_addr || port_we !== run_we || (run_we && port_wdata !== run_wd)) begin
            n_fail++;
            $display("FAIL rand_stable cyc%0d: addr=%h we=%b wdata=%h, want %h %b %h",
                     cyc, port_addr, port_we, port_wdata, run_addr, run_we, run_wd);
          end
        end
        if (port_we === 1'b1) dev_mem[port_addr[7:0]] = port_wdata;
      end
      if (iack_s) begin
        n_checks++;
        ok = if_pend && prev_en && run_len == LAT && run_addr == ia && !run_we &&
             if_rdata === ref_mem[ia[7:0]] && expect_next != 2;
        if (!ok) begin
          n_fail++;
          $display("FAIL rand_if_ack cyc%0d: pend=%b len=%0d addr=%h we=%b rdata=%h next=%0d, want 1 %0d %h 0 %h !=2",
                   cyc, if_pend, run_len, run_addr, run_we, if_rdata, expect_next, LAT, ia, ref_mem[ia[7:0]]);
        end
        n_iack++;
        expect_next = (mem_rd_req | mem_wr_req) ? 2 : 0;
      end
      if (mack_s) begin
        n_checks++;
        ok = m_pend && prev_en && run_len == LAT && run_addr == ma && run_we == m_wr &&
             (!m_wr || run_wd == mwd) && expect_next != 1;
        if (m_wr) begin
          ok = ok && (mem_rdata === ref_mrd);
          ref_mem[ma[7:0]] = mwd;
        end else begin
          ok = ok && (mem_rdata === ref_mem[ma[7:0]]);
          ref_mrd = ref_mem[ma[7:0]];
        end
        if (!ok) begin
          n_fail++;
          $display("FAIL rand_mem_ack cyc%0d: pend=%b len=%0d addr=%h we=%b rdata=%h next=%0d, want 1 %0d %h %b %h !=1",
                   cyc, m_pend, run_len, run_addr, run_we, mem_rdata, expect_next, LAT, ma, m_wr,
                   m_wr ? ref_mrd : ref_mem[ma[7:0]]);
        end
        n_mack++;
        expect_next = if_req ? 1 : 0;
      end
      if (if_pend && !iack_s) begin
        wait_if++;
        if (wait_if == BOUND) begin
          n_checks++; n_fail++;
          $display("FAIL rand_if_timeout cyc%0d: no if_ack after %0d cycles", cyc, BOUND);
        end
      end
      if (m_pend && !mack_s) begin
        wait_m++;
        if (wait_m == BOUND) begin
          n_checks++; n_fail++;
          $display("FAIL rand_mem_timeout cyc%0d: no mem_ack after %0d cycles", cyc, BOUND);
        end
      end
      prev_en = (port_en === 1'b1);
      @(posedge clk); #1;
      if (iack_s) if_pend = 0;
      if (mack_s) m_pend = 0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; wait_if = 0;
        ia = AW'($urandom_range(0, 31));
      end
      if (!m_pend && $urandom_range(0, 2) == 0) begin
        m_pend = 1; wait_m = 0;
        m_wr = ($urandom_range(0, 1) == 1);
        ma   = AW'($urandom_range(0, 31));
        mwd  = DW'($urandom);
      end
      if_req     = if_pend;
      if_addr    = ia;
      mem_rd_req = m_pend && !m_wr;
      mem_wr_req = m_pend && m_wr;
      mem_addr   = ma;
      mem_wdata  = mwd;
    end
    drive_idle();
    repeat (2 * (LAT + 2)) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (proto_err !== 1'b0 || n_iack < 20 || n_mack < 20) begin
      n_fail++;
      $display("FAIL rand_summary: proto_err=%b if_acks=%0d mem_acks=%0d, want 0 >=20 >=20",
               proto_err, n_iack, n_mack);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    if_addr   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    exp_mem_rdata = '0;
    drive_idle();
    for (int i = 0; i < 256; i++) dev_mem[i] = DW'($urandom);
    test_reset();
    test_if_fetch();
    test_if_mem_both();
    test_store();
    test_drop();
    test_alternate();
    test_rdwr_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
